// File: rtl/i2c_command_sequencer_pkg.sv
// Shared types and defaults for the I2C command sequencer.
//  state_e : sequencer FSM states
//  DEF_*   : default parameter values used by the top and its FIFO
package i2c_command_pkg;
  localparam int DEF_DATA_BYTES     = 1;
  localparam int DEF_REGISTER_BYTES = 1;
  localparam int DEF_ADDRESS_WIDTH  = 7;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_START_TIMEOUT  = 255;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESPOND} state_e;
endpackage

// File: rtl/i2c_command_sequencer_if.sv
// Bundle of the command, response and i2c_master control signals.
//  slave  : the sequencer's view (takes commands, drives responses and master_*)
//  master : the user/environment view (offers commands, models i2c_master)
interface i2c_command_sequencer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int REGISTER_WIDTH = 8,
  parameter int ADDRESS_WIDTH  = 7,
  parameter int LEVEL_WIDTH    = 3
);
  logic                      command_valid;
  logic                      command_ready;
  logic                      command_read_write;
  logic [ADDRESS_WIDTH-1:0]  command_device_address;
  logic [REGISTER_WIDTH-1:0] command_register_address;
  logic [DATA_WIDTH-1:0]     command_data;
  logic [15:0]               divider;
  logic                      response_valid;
  logic [DATA_WIDTH-1:0]     response_data;
  logic                      response_error;
  logic [LEVEL_WIDTH-1:0]    queue_level;
  logic                      idle;
  logic                      master_enable;
  logic                      master_read_write;
  logic [DATA_WIDTH-1:0]     master_mosi_data;
  logic [REGISTER_WIDTH-1:0] master_register_address;
  logic [ADDRESS_WIDTH-1:0]  master_device_address;
  logic [15:0]               master_divider;
  logic [DATA_WIDTH-1:0]     master_miso_data;
  logic                      master_busy;

  modport slave (
    input  command_valid, command_read_write, command_device_address,
           command_register_address, command_data, divider,
           master_miso_data, master_busy,
    output command_ready, response_valid, response_data, response_error,
           queue_level, idle, master_enable, master_read_write,
           master_mosi_data, master_register_address, master_device_address,
           master_divider
  );

  modport master (
    output command_valid, command_read_write, command_device_address,
           command_register_address, command_data, divider,
           master_miso_data, master_busy,
    input  command_ready, response_valid, response_data, response_error,
           queue_level, idle, master_enable, master_read_write,
           master_mosi_data, master_register_address, master_device_address,
           master_divider
  );
endinterface

// File: rtl/i2c_command_sequencer_fifo.sv
// Show-ahead command FIFO (head word visible while not empty).
//  push/push_data : write when not full (push while full is ignored)
//  pop            : advance head when not empty
//  head           : current oldest entry
//  full/empty/level : occupancy status
module i2c_command_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  assign level   = LW'(wr_q - rd_q);
  assign full    = (level == LW'(DEPTH));
  assign empty   = (wr_q == rd_q);
  assign head    = mem[rd_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/i2c_command_sequencer.sv
// Command front-end for i2c_master: queues register read/write commands,
// launches them one at a time via enable/busy and returns one response
// pulse per command (read data or zero, plus a start-timeout error).
//  clock, reset_n : system clock, async active-low reset
//  bus (slave)    : command valid/ready, response, queue status, i2c_master controls
module i2c_command_sequencer
  import i2c_command_pkg::*;
#(
  parameter int NUMBER_OF_DATA_BYTES     = DEF_DATA_BYTES,
  parameter int NUMBER_OF_REGISTER_BYTES = DEF_REGISTER_BYTES,
  parameter int ADDRESS_WIDTH            = DEF_ADDRESS_WIDTH,
  parameter int FIFO_DEPTH               = DEF_FIFO_DEPTH,
  parameter int START_TIMEOUT            = DEF_START_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  i2c_command_sequencer_if.slave bus
);
  localparam int DW    = 8*NUMBER_OF_DATA_BYTES;
  localparam int REG_W = 8*NUMBER_OF_REGISTER_BYTES;
  localparam int AW    = ADDRESS_WIDTH;
  localparam int CMD_W = 1 + AW + REG_W + DW;
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int CNT_W = $clog2(START_TIMEOUT+1);

  logic [CMD_W-1:0] fifo_head;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;

  state_e           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             rv_q, rv_d;
  logic             rerr_q, rerr_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             mrw_q, mrw_d;
  logic [AW-1:0]    mdev_q, mdev_d;
  logic [REG_W-1:0] mreg_q, mreg_d;
  logic [DW-1:0]    mdata_q, mdata_d;
  logic [15:0]      mdiv_q, mdiv_d;

  assign fifo_push = bus.command_valid && !fifo_full;
  // Never launch while i2c_master still reports busy (covers reset mid-transfer).
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty && !bus.master_busy;

  i2c_command_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data ({bus.command_read_write, bus.command_device_address,
                 bus.command_register_address, bus.command_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    rv_d    = 1'b0;
    rerr_d  = rerr_q;
    rdata_d = rdata_q;
    mrw_d   = mrw_q;
    mdev_d  = mdev_q;
    mreg_d  = mreg_q;
    mdata_d = mdata_q;
    mdiv_d  = mdiv_q;
    case (state_q)
      IDLE: if (fifo_pop) begin
        cmd_d   = fifo_head;
        state_d = LOAD;
      end
      LOAD: begin
        {mrw_d, mdev_d, mreg_d, mdata_d} = cmd_q;
        mdiv_d  = bus.divider;
        cnt_d   = '0;
        en_d    = 1'b1;
        state_d = START;
      end
      START: begin
        if (bus.master_busy) begin
          state_d = WAIT;
        end else if (cnt_q == CNT_W'(START_TIMEOUT-1)) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
          rv_d    = 1'b1;
          state_d = RESPOND;
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: if (!bus.master_busy) begin
        rdata_d = mrw_q ? bus.master_miso_data : '0;
        rerr_d  = 1'b0;
        rv_d    = 1'b1;
        state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
      mrw_q   <= 1'b0;
      mdev_q  <= '0;
      mreg_q  <= '0;
      mdata_q <= '0;
      mdiv_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
      mrw_q   <= mrw_d;
      mdev_q  <= mdev_d;
      mreg_q  <= mreg_d;
      mdata_q <= mdata_d;
      mdiv_q  <= mdiv_d;
    end
  end

  assign bus.command_ready           = !fifo_full;
  assign bus.queue_level             = fifo_level;
  assign bus.idle                    = (state_q == IDLE) && fifo_empty;
  assign bus.response_valid          = rv_q;
  assign bus.response_data           = rdata_q;
  assign bus.response_error          = rerr_q;
  assign bus.master_enable           = en_q;
  assign bus.master_read_write       = mrw_q;
  assign bus.master_device_address   = mdev_q;
  assign bus.master_register_address = mreg_q;
  assign bus.master_mosi_data        = mdata_q;
  assign bus.master_divider          = mdiv_q;
endmodule
